stm32_bus_master: RTL and testbench

STM32_BUS_MASTER -- requirements
Module: stm32_bus_master

---
 rtl/stm32_bus_pkg.sv | 44 ++++
 rtl/stm32_bus_master.sv | 108 ++++++++++
 tb/tb_stm32_bus_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stm32_bus_pkg.sv
// stm32_bus_pkg: command codes, master state encoding and default payload
// lengths shared by the STM32 bus master and its environment.
package stm32_bus_pkg;

  // Command byte values sent during the sync cycle
  localparam logic [7:0] CMD_BUS_TEST   = 8'h00;
  localparam logic [7:0] CMD_SET_PARAMS = 8'h01;
  localparam logic [7:0] CMD_GET_PARAMS = 8'h02;
  localparam logic [7:0] CMD_TX_IQ      = 8'h03;
  localparam logic [7:0] CMD_RX_IQ      = 8'h04;
  localparam logic [7:0] CMD_RESET_ON   = 8'h05;
  localparam logic [7:0] CMD_RESET_OFF  = 8'h06;
  localparam logic [7:0] CMD_GET_INFO   = 8'h08;

  // Default data-phase lengths in bytes
  localparam logic [7:0] LEN_SET_PARAMS = 8'd20;
  localparam logic [7:0] LEN_GET_PARAMS = 8'd8;
  localparam logic [7:0] LEN_TX_IQ      = 8'd8;
  localparam logic [7:0] LEN_RX_IQ_8    = 8'd8;
  localparam logic [7:0] LEN_RX_IQ_16   = 8'd16;
  localparam logic [7:0] LEN_GET_INFO   = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ,
    ST_GAP
  } state_t;

  // Default data-phase length for a command; RX IQ assumes 8-bit samples.
  function automatic logic [7:0] default_len(input logic [7:0] code);
    case (code)
      CMD_SET_PARAMS: return LEN_SET_PARAMS;
      CMD_GET_PARAMS: return LEN_GET_PARAMS;
      CMD_TX_IQ:      return LEN_TX_IQ;
      CMD_RX_IQ:      return LEN_RX_IQ_8;
      CMD_GET_INFO:   return LEN_GET_INFO;
      default:        return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/stm32_bus_master.sv
// stm32_bus_master: byte-wide master for the STM32 responder bus. Issues a
// one-cycle sync strobe carrying the command byte, then writes or reads
// cmd_len data bytes over the shared tristate bus, then idles for a gap.
module stm32_bus_master
  import stm32_bus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_take,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       underrun,
  output logic       DATA_SYNC,
  inout  wire  [7:0] DATA_BUS
);

  // The single counter is reused per state: wait cycles, byte index, gap cycles.
  localparam logic [7:0] WAIT_LAST = (RD_LATENCY > 1) ? 8'(RD_LATENCY - 2) : 8'd0;
  localparam logic [7:0] GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state, state_nx;
  logic [7:0] code_q, len_q, cnt, bus_out;
  logic       dir_q, rdy_en, out_en, last_byte, accept;

  assign cmd_ready = (state == ST_IDLE) && rdy_en;
  assign accept    = cmd_valid && cmd_ready;
  assign last_byte = (cnt == len_q - 8'd1);
  assign done      = (state == ST_GAP) && (cnt == '0);
  assign DATA_BUS  = out_en ? bus_out : 'z;

  // Next-state and bus-side outputs; the bus is only driven in SYNC and WRITE
  always_comb begin
    state_nx  = state;
    out_en    = 1'b0;
    bus_out   = '0;
    wr_take   = 1'b0;
    DATA_SYNC = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_SYNC;
      ST_SYNC: begin
        DATA_SYNC = 1'b1;
        out_en    = 1'b1;
        bus_out   = code_q;
        if (len_q == '0)         state_nx = ST_GAP;
        else if (dir_q)          state_nx = ST_WRITE;
        else if (RD_LATENCY > 1) state_nx = ST_RD_WAIT;
        else                     state_nx = ST_READ;
      end
      ST_WRITE: begin
        // Missing data does not stall the bus: a zero byte goes out instead
        out_en  = 1'b1;
        bus_out = wr_valid ? wr_data : '0;
        wr_take = wr_valid && reset_n;
        if (last_byte) state_nx = ST_GAP;
      end
      ST_RD_WAIT: if (cnt == WAIT_LAST) state_nx = ST_READ;
      ST_READ:    if (last_byte)        state_nx = ST_GAP;
      ST_GAP:     if (cnt == GAP_LAST)  state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // State register and per-state cycle counter (cleared on every state change)
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      cnt    <= (state_nx != state || state_nx == ST_IDLE) ? '0 : cnt + 8'd1;
    end
  end

  // Command latch, read capture and sticky underrun flag
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      code_q   <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rd_valid <= (state == ST_READ);
      if (state == ST_READ) rd_data <= DATA_BUS;
      if (state == ST_WRITE && !wr_valid) underrun <= 1'b1;
      if (accept) begin
        code_q <= cmd_code;
        len_q  <= cmd_len;
        dir_q  <= cmd_dir;
      end
    end
  end

endmodule

// File: tb/tb_stm32_bus_master.sv
// tb_stm32_bus_master: randomized bench with a transaction-timeline reference
// model and a responder that drives read bytes on the shared bus.
module tb_stm32_bus_master;
  import stm32_bus_pkg::*;

  localparam int G  = 2;
  localparam int RL = 2;

  logic       clk_in    = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_code  = '0;
  logic       cmd_dir   = 1'b0;
  logic [7:0] cmd_len   = '0;
  logic [7:0] wr_data   = '0;
  logic       wr_valid  = 1'b0;
  logic       cmd_ready, wr_take, rd_valid, done, underrun, DATA_SYNC;
  logic [7:0] rd_data;
  wire  [7:0] DATA_BUS;

  logic       resp_oe   = 1'b0;
  logic [7:0] resp_byte = '0;
  assign DATA_BUS = resp_oe ? resp_byte : 'z;

  stm32_bus_master #(.GAP_CYCLES(G), .RD_LATENCY(RL)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_take(wr_take), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .underrun(underrun), .DATA_SYNC(DATA_SYNC), .DATA_BUS(DATA_BUS)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycle k is the interval after rising edge k
  int         cyc = 0;
  bit         act = 0, rdy = 0, um = 0, armed = 0;
  int         t_acc = 0;
  logic [7:0] m_code = '0;
  bit         m_dir = 0;
  int         m_len = 0;
  logic [7:0] wbuf [256];
  logic [7:0] rbuf [256];
  logic [7:0] codes [8];
  int         take_cnt = 0, rv_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Offsets relative to the sync cycle (offset 0)
  function automatic int done_at();
    if (m_len == 0) return 1;
    return m_dir ? m_len + 1 : m_len + RL;
  endfunction

  function automatic int ready_at();
    return done_at() + G;
  endfunction

  // Model update at each edge, plus the responder's drive for the next cycle
  always @(posedge clk_in) begin
    int r_end, r_nx;
    r_end = cyc - t_acc;
    if (!reset_n) begin
      act = 0; rdy = 0; um = 0; armed = 1;
    end else begin
      if (act && m_dir && r_end >= 1 && r_end <= m_len && !wr_valid) um = 1;
      if (act && r_end >= ready_at()) act = 0;
      if (!act && rdy && cmd_valid) begin
        act = 1; t_acc = cyc + 1;
        m_code = cmd_code; m_dir = cmd_dir; m_len = int'(cmd_len);
      end
      rdy = 1;
    end
    cyc = cyc + 1;
    r_nx = cyc - t_acc;
    if (act && !m_dir && r_nx >= RL && r_nx < RL + m_len) begin
      resp_oe <= 1'b1; resp_byte <= rbuf[r_nx - RL];
    end else begin
      resp_oe <= 1'b0; resp_byte <= '0;
    end
  end

  // Mid-cycle comparison of every output against the model timeline
  always @(negedge clk_in) begin
    int r;
    bit busy, wr_win, e_sync, e_oe, e_take, e_rv, e_done;
    logic [7:0] e_bus;
    if (armed) begin
      r = cyc - t_acc;
      busy = act && r < ready_at();
      e_sync = 0; e_oe = 0; e_take = 0; e_rv = 0; e_done = 0; e_bus = '0;
      if (busy) begin
        e_sync = (r == 0);
        wr_win = m_dir && r >= 1 && r <= m_len;
        e_oe   = e_sync || wr_win;
        e_bus  = e_sync ? m_code : (wr_valid ? wr_data : 8'h00);
        e_take = wr_win && wr_valid;
        e_rv   = !m_dir && r >= RL + 1 && r <= m_len + RL;
        e_done = (r == done_at());
      end
      check("cmd_ready", cmd_ready, rdy && !busy);
      check("data_sync", DATA_SYNC, e_sync);
      check("master_oe", dut.out_en, e_oe);
      check("contention", dut.out_en && resp_oe, 0);
      if (e_oe) check("bus", DATA_BUS, e_bus);
      check("wr_take", wr_take, e_take);
      check("rd_valid", rd_valid, e_rv);
      if (e_rv) check("rd_data", rd_data, rbuf[r - RL - 1]);
      if (!rdy) check("rd_data_rst", rd_data, 0);
      check("done", done, e_done);
      check("underrun", underrun, um);
      take_cnt += int'(wr_take);
      rv_cnt   += int'(rd_valid);
      done_cnt += int'(done);
    end
  end

  task automatic wait_accept(output bit ok);
    int guard = 0;
    ok = 0;
    while (!ok && guard < 64) begin
      @(posedge clk_in); #1;
      guard++;
      ok = act && (t_acc == cyc);
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] code, input bit dir, input int len,
                         input int drop, input int pct, input bit poke);
    bit ok;
    int guard;
    cmd_code = code; cmd_dir = dir; cmd_len = 8'(len); cmd_valid = 1'b1;
    wait_accept(ok);
    cmd_valid = 1'b0;
    if (!ok) return;
    cmd_code = 8'($urandom); cmd_len = 8'($urandom); cmd_dir = 1'($urandom);
    if (dir) begin
      for (int i = 0; i < len; i++) begin
        @(posedge clk_in); #1;
        wr_valid = (i != drop) && (int'($urandom_range(99)) < pct);
        wr_data  = wr_valid ? wbuf[i] : 8'($urandom);
        if (poke) cmd_valid = 1'($urandom_range(1));
      end
    end
    guard = 0;
    while (act && (cyc - t_acc) < ready_at() && guard < 600) begin
      @(posedge clk_in); #1;
      guard++;
      wr_valid = 1'b0; wr_data = 8'($urandom);
      cmd_valid = (poke && act && (cyc - t_acc) < ready_at()) ? 1'($urandom_range(1)) : 1'b0;
    end
    cmd_valid = 1'b0;
    if (guard >= 600) check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, r0, d0;
    bit ok;
    codes = '{CMD_BUS_TEST, CMD_SET_PARAMS, CMD_GET_PARAMS, CMD_TX_IQ,
              CMD_RX_IQ, CMD_RESET_ON, CMD_RESET_OFF, CMD_GET_INFO};
    repeat (3) @(posedge clk_in);
    #1 reset_n = 1'b1;
    @(posedge clk_in); #1;

    // Parameter write: 20 bytes 0x01..0x14
    for (int i = 0; i < 20; i++) wbuf[i] = 8'(i + 1);
    t0 = take_cnt;
    run_txn(CMD_SET_PARAMS, 1, 20, -1, 100, 0);
    check("take_count_20", take_cnt - t0, 20);

    // Info read: responder returns 02 03 00
    rbuf[0] = 8'h02; rbuf[1] = 8'h03; rbuf[2] = 8'h00;
    r0 = rv_cnt;
    run_txn(CMD_GET_INFO, 0, 3, -1, 100, 0);
    check("rv_count_3", rv_cnt - r0, 3);

    // Command only, both directions
    run_txn(CMD_RESET_ON, 0, 0, -1, 100, 0);
    run_txn(CMD_RESET_OFF, 1, 0, -1, 100, 1);

    // Underrun on byte 4 of a TX IQ write
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(1, 255));
    t0 = take_cnt;
    run_txn(CMD_TX_IQ, 1, 8, 4, 100, 0);
    check("take_count_underrun", take_cnt - t0, 7);

    // Reset while read byte 5 of 8 is on the bus
    for (int i = 0; i < 8; i++) rbuf[i] = 8'($urandom_range(1, 255));
    r0 = rv_cnt; d0 = done_cnt;
    cmd_code = CMD_RX_IQ; cmd_dir = 1'b0; cmd_len = 8'd8; cmd_valid = 1'b1;
    wait_accept(ok);
    cmd_valid = 1'b0;
    if (ok) begin
      while ((cyc - t_acc) < 5 + RL) begin @(posedge clk_in); #1; end
    end
    reset_n = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    @(posedge clk_in); #1;
    check("rv_count_rst", rv_cnt - r0, 5);
    check("done_count_rst", done_cnt - d0, 0);

    // Maximum length in both directions
    for (int i = 0; i < 256; i++) begin wbuf[i] = 8'($urandom); rbuf[i] = 8'($urandom); end
    t0 = take_cnt;
    run_txn(CMD_TX_IQ, 1, 255, -1, 100, 1);
    check("take_count_255", take_cnt - t0, 255);
    r0 = rv_cnt;
    run_txn(CMD_RX_IQ, 0, 255, -1, 100, 1);
    check("rv_count_255", rv_cnt - r0, 255);

    // Random traffic with occasional gaps, underruns and ignored requests
    for (int n = 0; n < 40; n++) begin
      logic [7:0] code;
      int len;
      code = codes[$urandom_range(7)];
      len  = ($urandom_range(3) == 0) ? int'(default_len(code)) : int'($urandom_range(30));
      for (int i = 0; i < 256; i++) begin wbuf[i] = 8'($urandom); rbuf[i] = 8'($urandom); end
      r0 = rv_cnt; d0 = done_cnt;
      run_txn(code, 1'($urandom_range(1)), len, -1, ($urandom_range(1) == 1) ? 100 : 80,
              1'($urandom_range(1)));
      check("done_count_rand", done_cnt - d0, 1);
      repeat ($urandom_range(3)) begin @(posedge clk_in); #1; end
    end

    repeat (4) @(posedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
